// File: rtl/skintone_stream_pkg.sv
// Shared types, constants and the pixel pattern generator for the skintone
// stream driver and its watchdog.
package skintone_stream_pkg;

    localparam int unsigned LANE_WIDTH       = 32;
    localparam int unsigned STALL_MASK_WIDTH = 8;
    localparam int unsigned LANE_HALF_WIDTH  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_OPCODE,
        S_STREAM,
        S_DONE,
        S_ERROR
    } stream_state_t;

    // One 32-bit lane of a pixel beat: beat index in the upper half, lane number below.
    function automatic logic [LANE_WIDTH-1:0] lane_pattern(
        input logic [LANE_HALF_WIDTH-1:0] idx,
        input logic [LANE_HALF_WIDTH-1:0] lane
    );
        return {idx, lane};
    endfunction

endpackage

// File: rtl/skintone_stream_watchdog.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags
// expiry once C_TIMEOUT-1 is reached.
module skintone_stream_watchdog #(
    parameter int unsigned C_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int unsigned CNT_WIDTH = $clog2(C_TIMEOUT + 1);

    logic [CNT_WIDTH-1:0] count;

    // Saturates at the expiry value so a stuck enable cannot wrap around.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

    assign expire = (count == CNT_WIDTH'(C_TIMEOUT - 1));

endmodule

// File: rtl/skintone_stream_driver.sv
// Bring-up traffic engine for the skintone accelerator: one config write, one
// opcode, then a stalled pixel stream with result counting and checksumming.
module skintone_stream_driver
    import skintone_stream_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH           = 128,
    parameter int unsigned C_CONFIG_ADDRESS_WIDTH = 36,
    parameter int unsigned C_CONFIG_DATA_WIDTH    = 128,
    parameter int unsigned C_OPCODE_WIDTH         = 16,
    parameter int unsigned C_COUNT_WIDTH          = 16,
    parameter int unsigned C_TIMEOUT              = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [C_COUNT_WIDTH-1:0]          beat_count,
    input  logic [C_CONFIG_ADDRESS_WIDTH-1:0] cfg_addr,
    input  logic [C_CONFIG_DATA_WIDTH-1:0]    cfg_data,
    input  logic [C_OPCODE_WIDTH-1:0]         op_in,
    input  logic [STALL_MASK_WIDTH-1:0]       tx_stall_mask,
    input  logic [STALL_MASK_WIDTH-1:0]       rx_stall_mask,
    output logic [C_CONFIG_ADDRESS_WIDTH-1:0] config_address,
    output logic [C_CONFIG_DATA_WIDTH-1:0]    config_datain,
    output logic                              config_wrreq,
    input  logic                              config_wrack,
    output logic [C_OPCODE_WIDTH-1:0]         opcode,
    output logic                              opcode_valid,
    input  logic                              opcode_accept,
    output logic [C_DATA_WIDTH-1:0]           tx_data,
    output logic                              tx_valid,
    input  logic                              tx_ready,
    input  logic [C_DATA_WIDTH-1:0]           rx_data,
    input  logic                              rx_valid,
    output logic                              rx_ready,
    output logic [C_COUNT_WIDTH-1:0]          tx_count,
    output logic [C_COUNT_WIDTH-1:0]          rx_count,
    output logic [C_DATA_WIDTH-1:0]           rx_checksum,
    output logic                              done,
    output logic                              error
);
    localparam int unsigned NUM_LANES = C_DATA_WIDTH / LANE_WIDTH;
    localparam int unsigned IDX_WIDTH = $clog2(STALL_MASK_WIDTH);

    stream_state_t state, state_next;

    logic [C_COUNT_WIDTH-1:0] beat_q;
    logic [C_COUNT_WIDTH-1:0] tx_count_next;
    logic [C_COUNT_WIDTH-1:0] rx_count_next;
    logic [IDX_WIDTH-1:0]     cyc;
    logic [IDX_WIDTH-1:0]     cyc_next;
    logic [IDX_WIDTH-1:0]     tx_idx;
    logic [C_DATA_WIDTH-1:0]  tx_pattern;
    logic stall_done;
    logic tx_fire;
    logic rx_fire;
    logic run_start;
    logic complete;
    logic tx_free;
    logic tx_want;
    logic tx_stall;
    logic tx_load;
    logic wd_clear;
    logic wd_enable;
    logic wd_expire;

    // Handshake decode and post-edge counter values.
    always_comb begin
        tx_fire       = tx_valid & tx_ready;
        rx_fire       = rx_valid & rx_ready;
        run_start     = (state == S_IDLE) && start;
        tx_count_next = tx_count + C_COUNT_WIDTH'(tx_fire);
        rx_count_next = rx_count + C_COUNT_WIDTH'(rx_fire);
        complete      = (tx_count_next == beat_q) && (rx_count_next == beat_q);
        cyc_next      = run_start ? '0 : cyc + IDX_WIDTH'(1);
        tx_idx        = tx_count_next[IDX_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_CONFIG;
            end
            S_CONFIG: begin
                if (config_wrack)   state_next = S_OPCODE;
                else if (wd_expire) state_next = S_ERROR;
            end
            S_OPCODE: begin
                if (opcode_accept)  state_next = (beat_q == '0) ? S_DONE : S_STREAM;
                else if (wd_expire) state_next = S_ERROR;
            end
            S_STREAM: begin
                if (complete)                             state_next = S_DONE;
                else if (wd_expire && !tx_fire && !rx_fire) state_next = S_ERROR;
            end
            S_DONE:  state_next = S_IDLE;
            S_ERROR: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // A free transmit slot with beats left either loads the next beat or burns one stall cycle.
    always_comb begin
        wd_enable = (state == S_CONFIG) || (state == S_OPCODE) || (state == S_STREAM);
        wd_clear  = (state_next != state) || tx_fire || rx_fire;
        tx_free   = !tx_valid || tx_fire;
        tx_want   = (state_next == S_STREAM) && tx_free && (tx_count_next < beat_q);
        tx_stall  = tx_stall_mask[tx_idx] && !stall_done;
        tx_load   = tx_want && !tx_stall;
    end

    always_comb begin
        tx_pattern = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            tx_pattern[i*LANE_WIDTH +: LANE_WIDTH] =
                lane_pattern(LANE_HALF_WIDTH'(tx_count_next), LANE_HALF_WIDTH'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            config_address <= '0;
            config_datain  <= '0;
            config_wrreq   <= 1'b0;
            opcode         <= '0;
            opcode_valid   <= 1'b0;
            tx_data        <= '0;
            tx_valid       <= 1'b0;
            rx_ready       <= 1'b0;
            tx_count       <= '0;
            rx_count       <= '0;
            rx_checksum    <= '0;
            done           <= 1'b0;
            error          <= 1'b0;
            beat_q         <= '0;
            cyc            <= '0;
            stall_done     <= 1'b0;
        end else begin
            cyc          <= cyc_next;
            config_wrreq <= (state_next == S_CONFIG);
            opcode_valid <= (state_next == S_OPCODE);
            done         <= (state_next == S_DONE);
            rx_ready     <= (state_next == S_STREAM) && (rx_count_next < beat_q)
                            && !rx_stall_mask[cyc_next];
            if (run_start) begin
                config_address <= cfg_addr;
                config_datain  <= cfg_data;
                opcode         <= op_in;
                beat_q         <= beat_count;
                tx_count       <= '0;
                rx_count       <= '0;
                rx_checksum    <= '0;
                error          <= 1'b0;
                stall_done     <= 1'b0;
            end else begin
                tx_count <= tx_count_next;
                rx_count <= rx_count_next;
                if (rx_fire)                 rx_checksum <= rx_checksum ^ rx_data;
                if (state_next == S_ERROR)   error       <= 1'b1;
            end
            // tx_valid only falls after a handshake, or when the stream is abandoned.
            if (tx_load) begin
                tx_valid   <= 1'b1;
                tx_data    <= tx_pattern;
                stall_done <= 1'b0;
            end else if (tx_free || (state_next != S_STREAM)) begin
                tx_valid <= 1'b0;
                if (tx_want) stall_done <= 1'b1;
            end
        end
    end

    skintone_stream_watchdog #(
        .C_TIMEOUT (C_TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

endmodule
